rpi_shift_master: RTL

RPI_SHIFT_MASTER -- requirements
Module: rpi_shift_master

---
 rtl/rpi_shift_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rpi_shift_master.sv
// Two-port round-robin serial shift master for a register bank: MSB-first shift, latch strobe, done pulse.
// Optional readback capture of rpi_sdata_out is enabled by defining SHIFT_READBACK_EN.
module rpi_shift_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_regsel,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_regsel,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rpi_sclk,
  output logic [1:0] rpi_regsel,
  output logic       rpi_sdata_in,
  output logic       rpi_sle,
  input  logic       rpi_sdata_out,
  output logic       done,
  output logic       done_port,
  output logic [7:0] rsp_data
);

  localparam int          DATA_W     = 8;
  localparam logic [7:0]  CNT_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_cnt;
  logic                r_last;
  logic                r_port;
  logic                r_done_port;
  logic [1:0]          r_regsel;
  logic [DATA_W-1:0]   r_data;
  logic [2:0]          r_bit;
  logic                w_phase_end;
  logic                w_accept;
  logic                w_done_entry;

  always_comb begin
    w_next       = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rpi_sclk     = 1'b0;
    rpi_sdata_in = 1'b0;
    rpi_sle      = 1'b0;
    rpi_regsel   = 2'b11;
    done         = 1'b0;
    w_phase_end  = (r_cnt == 8'd0);
    case (r_state)
      IDLE: begin
        // r_last=1 means port 1 was served last, so port 0 wins a tie
        if (req0_valid && (!req1_valid || r_last)) begin
          req0_ready = 1'b1;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          w_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        rpi_sdata_in = r_data[r_bit];
        rpi_regsel   = r_regsel;
        if (w_phase_end) w_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        rpi_sclk     = 1'b1;
        rpi_sdata_in = r_data[r_bit];
        rpi_regsel   = r_regsel;
        if (w_phase_end) w_next = (r_bit == 3'd0) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        rpi_sle    = 1'b1;
        rpi_regsel = r_regsel;
        if (w_phase_end) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_done_entry = (r_state == LATCH) && (w_next == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= CNT_RELOAD;
      r_last      <= 1'b1;
      r_port      <= 1'b0;
      r_done_port <= 1'b0;
    end else begin
      r_state <= w_next;
      // every phase boundary is a state change, so reloading on change times each phase
      if (w_next != r_state) begin
        r_cnt <= CNT_RELOAD;
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_accept) begin
        r_last <= req1_ready;
        r_port <= req1_ready;
      end
      if (w_done_entry) r_done_port <= r_port;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_regsel <= req1_ready ? req1_regsel : req0_regsel;
      r_data   <= req1_ready ? req1_data   : req0_data;
      r_bit    <= 3'd7;
    end else if ((r_state == SHIFT_HI) && (w_next == SHIFT_LO)) begin
      r_bit <= r_bit - 3'd1;
    end
  end

  assign done_port = r_done_port;

`ifdef SHIFT_READBACK_EN
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rsp;

  // sample once per bit, on the first cycle with sclk high
  always_ff @(posedge clk) begin
    if ((r_state == SHIFT_HI) && (r_cnt == CNT_RELOAD)) begin
      r_rx <= {r_rx[DATA_W-2:0], rpi_sdata_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp <= '0;
    end else if (w_done_entry) begin
      r_rsp <= r_rx;
    end
  end

  assign rsp_data = r_rsp;
`else
  logic w_unused_sdata;
  assign w_unused_sdata = rpi_sdata_out;
  assign rsp_data       = '0;
`endif

endmodule
